vr_fetch_unit: RTL and testbench



---
 rtl/vr_fetch_unit_if.sv | 23 ++
 rtl/vr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_vr_fetch_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vr_fetch_unit_if.sv
// rtl/vr_fetch_unit_if.sv - fetch unit bus: imem address/data, redirect, decode handshake, status
interface vr_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        halted;
  logic        misalign_err;

  modport master (
    output imem_addr, out_valid, out_inst, out_pc, halted, misalign_err,
    input  imem_inst, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_inst, out_pc, halted, misalign_err,
    output imem_inst, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/vr_fetch_unit.sv
// rtl/vr_fetch_unit.sv - instruction fetch front end with PC, instruction FIFO and redirect
module vr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  vr_fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {RUN, FULL, HALT} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               misalign_q, misalign_d;
  logic [31:0]        pc_mem_q   [DEPTH];
  logic [31:0]        inst_mem_q [DEPTH];

  logic               out_valid;
  logic               deq;
  logic               fetch_en;
  logic               zero_word;
  logic               enq;

  assign out_valid        = (count_q != '0);
  assign bus.imem_addr    = pc_q;
  assign bus.out_valid    = out_valid;
  assign bus.out_inst     = inst_mem_q[rd_ptr_q];
  assign bus.out_pc       = pc_mem_q[rd_ptr_q];
  assign bus.halted       = (state_q == HALT);
  assign bus.misalign_err = misalign_q;

  // A full buffer may still fetch when decode frees the head in the same cycle.
  always_comb begin
    deq       = out_valid && bus.out_ready;
    fetch_en  = (state_q != HALT) && !bus.redirect_valid &&
                ((count_q < CNT_W'(DEPTH)) || deq);
    zero_word = (bus.imem_inst == 32'h0);
    enq       = fetch_en && !zero_word;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    misalign_d = misalign_q;

    if (bus.redirect_valid) begin
      state_d    = RUN;
      pc_d       = {bus.redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      misalign_d = misalign_q | (|bus.redirect_pc[1:0]);
    end else begin
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        pc_d     = pc_q + 32'd4;
      end
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);

      case (state_q)
        RUN, FULL: begin
          if (fetch_en && zero_word) begin
            state_d = HALT;
          end else if (count_d == CNT_W'(DEPTH)) begin
            state_d = FULL;
          end else begin
            state_d = RUN;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Entries are cleared on reset so the head reads zero right after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (enq) begin
      pc_mem_q[wr_ptr_q]   <= pc_q;
      inst_mem_q[wr_ptr_q] <= bus.imem_inst;
    end
  end

endmodule

// File: tb/tb_vr_fetch_unit.sv
// tb/tb_vr_fetch_unit.sv - self-checking bench for vr_fetch_unit: vector table, corner sequence, random vs queue model
module tb_vr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk;
  logic reset;
  vr_fetch_unit_if bus();

  vr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [64];
  assign bus.imem_inst = mem[bus.imem_addr[7:2]];

  int n_cmp;
  int n_bad;

  typedef struct {
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        chk_out;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [31:0] eaddr;
    logic        eh;
    logic        em;
  } vec_t;

  vec_t tbl [22];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq [$];
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_mis;
  bit          m_fresh;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(logic ready, logic rv, logic [31:0] rpc, logic chk_out, logic ev,
                               logic [31:0] epc, logic [31:0] einst, logic [31:0] eaddr,
                               logic eh, logic em);
    vec_t v;
    v.ready = ready; v.rv = rv; v.rpc = rpc; v.chk_out = chk_out; v.ev = ev;
    v.epc = epc; v.einst = einst; v.eaddr = eaddr; v.eh = eh; v.em = em;
    return v;
  endfunction

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc, input logic rst);
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    reset              = rst;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    reset = 1'b0;
  endtask

  // Reference: queue of {pc, inst} advanced by the fetch rules, one call per clock edge.
  task automatic m_step(input bit rdy, input bit rv, input logic [31:0] rpc, input bit rst);
    logic [31:0] w;
    if (rst) begin
      mq.delete();
      m_pc = RESET_PC; m_halt = 0; m_mis = 0; m_fresh = 1;
      return;
    end
    m_fresh = 0;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (rv) begin
      mq.delete();
      m_pc   = {rpc[31:2], 2'b00};
      m_halt = 0;
      if (rpc[1:0] != 2'b00) m_mis = 1;
    end else if (!m_halt && mq.size() < DEPTH) begin
      w = mem[m_pc[7:2]];
      if (w != 32'h0) begin
        mq.push_back({m_pc, w});
        m_pc = m_pc + 32'd4;
      end else begin
        m_halt = 1;
      end
    end
  endtask

  task automatic m_compare();
    chk("rnd_valid", {31'b0, bus.out_valid}, {31'b0, mq.size() > 0});
    chk("rnd_addr", bus.imem_addr, m_pc);
    chk("rnd_halted", {31'b0, bus.halted}, {31'b0, m_halt});
    chk("rnd_misalign", {31'b0, bus.misalign_err}, {31'b0, m_mis});
    if (mq.size() > 0) begin
      chk("rnd_out_pc", bus.out_pc, mq[0].pc);
      chk("rnd_out_inst", bus.out_inst, mq[0].inst);
    end else if (m_fresh) begin
      chk("rnd_rst_pc", bus.out_pc, 32'h0);
      chk("rnd_rst_inst", bus.out_inst, 32'h0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[0]  = 32'h0000_0533;
    mem[1]  = 32'h0000_0333;
    mem[2]  = 32'h0000_02b3;
    mem[14] = 32'h0000_0333;
    mem[18] = 32'h0000_8067;
    mem[19] = 32'h0000_0000;

    //             rdy   rv    rpc        chk   ev    epc       einst          eaddr     eh    em
    tbl[0]  = mkv(1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'h0,         32'h00, 1'b0, 1'b0);
    tbl[1]  = mkv(1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00, 32'h0000_0533, 32'h04, 1'b0, 1'b0);
    tbl[2]  = mkv(1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00, 32'h0000_0533, 32'h08, 1'b0, 1'b0);
    tbl[3]  = mkv(1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00, 32'h0000_0533, 32'h08, 1'b0, 1'b0);
    tbl[4]  = mkv(1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00, 32'h0000_0533, 32'h08, 1'b0, 1'b0);
    tbl[5]  = mkv(1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00, 32'h0000_0533, 32'h08, 1'b0, 1'b0);
    tbl[6]  = mkv(1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h04, 32'h0000_0333, 32'h0C, 1'b0, 1'b0);
    tbl[7]  = mkv(1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h08, 32'h0000_02b3, 32'h10, 1'b0, 1'b0);
    tbl[8]  = mkv(1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h0C, 32'hA000_0003, 32'h14, 1'b0, 1'b0);
    tbl[9]  = mkv(1'b0, 1'b1, 32'h38, 1'b0, 1'b1, 32'h10, 32'hA000_0004, 32'h18, 1'b0, 1'b0);
    tbl[10] = mkv(1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         32'h38, 1'b0, 1'b0);
    tbl[11] = mkv(1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h38, 32'h0000_0333, 32'h3C, 1'b0, 1'b0);
    tbl[12] = mkv(1'b1, 1'b1, 32'h0E, 1'b0, 1'b1, 32'h3C, 32'hA000_000F, 32'h40, 1'b0, 1'b0);
    tbl[13] = mkv(1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         32'h0C, 1'b0, 1'b1);
    tbl[14] = mkv(1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 32'h0C, 32'hA000_0003, 32'h10, 1'b0, 1'b1);
    tbl[15] = mkv(1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         32'h44, 1'b0, 1'b1);
    tbl[16] = mkv(1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h44, 32'hA000_0011, 32'h48, 1'b0, 1'b1);
    tbl[17] = mkv(1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h48, 32'h0000_8067, 32'h4C, 1'b0, 1'b1);
    tbl[18] = mkv(1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         32'h4C, 1'b1, 1'b1);
    tbl[19] = mkv(1'b1, 1'b1, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         32'h4C, 1'b1, 1'b1);
    tbl[20] = mkv(1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         32'h00, 1'b0, 1'b1);
    tbl[21] = mkv(1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00, 32'h0000_0533, 32'h04, 1'b0, 1'b1);

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].ready, tbl[i].rv, tbl[i].rpc, 1'b0);
      chk($sformatf("vec%0d_valid", i), {31'b0, bus.out_valid}, {31'b0, tbl[i].ev});
      chk($sformatf("vec%0d_addr", i), bus.imem_addr, tbl[i].eaddr);
      chk($sformatf("vec%0d_halted", i), {31'b0, bus.halted}, {31'b0, tbl[i].eh});
      chk($sformatf("vec%0d_misalign", i), {31'b0, bus.misalign_err}, {31'b0, tbl[i].em});
      if (tbl[i].ev || tbl[i].chk_out) begin
        chk($sformatf("vec%0d_out_pc", i), bus.out_pc, tbl[i].epc);
        chk($sformatf("vec%0d_out_inst", i), bus.out_inst, tbl[i].einst);
      end
      tick();
    end

    // Halt with an entry still buffered, then reset mid-run (misalign_err is still set here).
    drive(1'b0, 1'b1, 32'h48, 1'b0); tick();
    drive(1'b0, 1'b0, 32'h00, 1'b0); tick();
    drive(1'b0, 1'b0, 32'h00, 1'b0); tick();
    chk("seq_halted", {31'b0, bus.halted}, 32'h1);
    chk("seq_hold_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("seq_hold_pc", bus.out_pc, 32'h48);
    chk("seq_halt_addr", bus.imem_addr, 32'h4C);
    drive(1'b0, 1'b0, 32'h00, 1'b1); tick();
    drive(1'b1, 1'b0, 32'h00, 1'b0);
    chk("seq_rst_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("seq_rst_pc", bus.out_pc, 32'h0);
    chk("seq_rst_inst", bus.out_inst, 32'h0);
    chk("seq_rst_halted", {31'b0, bus.halted}, 32'h0);
    chk("seq_rst_misalign", {31'b0, bus.misalign_err}, 32'h0);
    chk("seq_rst_addr", bus.imem_addr, RESET_PC);
    tick();
    drive(1'b1, 1'b0, 32'h00, 1'b0);
    chk("seq_resume_pc0", bus.out_pc, 32'h0);
    chk("seq_resume_inst0", bus.out_inst, 32'h0000_0533);
    tick();
    drive(1'b1, 1'b0, 32'h00, 1'b0);
    chk("seq_resume_pc4", bus.out_pc, 32'h4);
    chk("seq_resume_inst4", bus.out_inst, 32'h0000_0333);
    tick();

    // Address wrap from the top of the address space.
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr_zero", bus.imem_addr, 32'h0);
    chk("wrap_out_pc", bus.out_pc, 32'hFFFF_FFFC);
    chk("wrap_out_inst", bus.out_inst, 32'hA000_003F);
    tick();

    for (int i = 0; i < 64; i++) begin
      mem[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    m_step(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    for (int c = 0; c < 3000; c++) begin
      logic        rdy, rv, rst;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = 32'hFFFF_FFFC;
        1:       rpc = 32'hFFFF_FFF8 | ($urandom & 32'h3);
        default: rpc = $urandom & 32'hFF;
      endcase
      drive(rdy, rv, rpc, rst);
      m_compare();
      m_step(rdy, rv, rpc, rst);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
